// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS32 control path: opcodes, functs, ALU codes, states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_pkg;

    localparam int STATE_BITS = 4;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    // ALU_control codes; these must stay in step with the ALU's own decode
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU operand B select
    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // Encoding is visible on the State debug port, so values are fixed
    typedef enum logic [STATE_BITS-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // Per-state control word before reset gating and PCEn formation
    typedef struct packed {
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        aluop_t     alu_op;
        logic [1:0] pc_src;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       mem_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the MIPS datapath.
// Latency: n/a (wiring only).
// Backpressure: none; the datapath follows the controls every cycle.
interface mips_multicycle_control_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       zero_sig;
    logic [2:0] ALU_control;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSrc;
    logic       IorD;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       PCEn;
    logic       Illegal_op;
    logic [3:0] State;

    // Control side: reads instruction fields and ALU flag, drives the datapath
    modport master (
        input  Op, Funct, zero_sig,
        output ALU_control, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
               RegDst, MemtoReg, RegWrite, PCEn, Illegal_op, State
    );

    // Datapath side
    modport slave (
        output Op, Funct, zero_sig,
        input  ALU_control, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
               RegDst, MemtoReg, RegWrite, PCEn, Illegal_op, State
    );

endinterface

// File: rtl/mips_alu_decoder.sv
// ALU decoder: maps ALUOp plus R-type Funct onto the ALU_control code.
// Latency: combinational.
// Backpressure: none.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  aluop_t     alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       bad_funct
);

    // Fixed add/sub for address and branch work, Funct-driven for R-type
    always_comb begin
        alu_control = ALU_ADD;
        bad_funct   = 1'b0;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD: alu_control = ALU_ADD;
                    FUNCT_SUB: alu_control = ALU_SUB;
                    FUNCT_AND: alu_control = ALU_AND;
                    FUNCT_OR:  alu_control = ALU_OR;
                    FUNCT_SLT: alu_control = ALU_SLT;
                    default: begin
                        // Unknown R-type: harmless add, flagged to the top
                        alu_control = ALU_ADD;
                        bad_funct   = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS32 main control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: lw 5, sw/R-type/addi 4, beq/j 3, illegal 2 cycles; outputs Moore-decoded from State.
// Backpressure: none; every state lasts exactly one clock.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mips_multicycle_control_if.master  ctl
);

    state_t     state;
    logic       mem_is_sw;
    logic       illegal_op;
    ctrl_t      c;
    logic [2:0] alu_control;
    logic       bad_funct;

    mips_alu_decoder u_alu_dec (
        .alu_op      (c.alu_op),
        .funct       (ctl.Funct),
        .alu_control (alu_control),
        .bad_funct   (bad_funct)
    );

    // State sequencing, lw/sw memory of the decoded op, and the illegal-op pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_FETCH;
            mem_is_sw  <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            illegal_op <= 1'b0;
            case (state)
                S_FETCH:  state <= S_DECODE;
                S_DECODE: begin
                    // Op is only looked at here; lw vs sw is remembered for MEMADR
                    case (ctl.Op)
                        OP_LW: begin
                            state     <= S_MEMADR;
                            mem_is_sw <= 1'b0;
                        end
                        OP_SW: begin
                            state     <= S_MEMADR;
                            mem_is_sw <= 1'b1;
                        end
                        OP_RTYPE: state <= S_EXECUTE;
                        OP_BEQ:   state <= S_BRANCH;
                        OP_ADDI:  state <= S_ADDIEX;
                        OP_J:     state <= S_JUMP;
                        default: begin
                            state      <= S_FETCH;
                            illegal_op <= 1'b1;
                        end
                    endcase
                end
                S_MEMADR:  state <= mem_is_sw ? S_MEMWR : S_MEMRD;
                S_MEMRD:   state <= S_MEMWB;
                S_MEMWB:   state <= S_FETCH;
                S_MEMWR:   state <= S_FETCH;
                S_EXECUTE: begin
                    // Unknown Funct still completes as an add, but is reported
                    state      <= S_ALUWB;
                    illegal_op <= bad_funct;
                end
                S_ALUWB:   state <= S_FETCH;
                S_BRANCH:  state <= S_FETCH;
                S_ADDIEX:  state <= S_ADDIWB;
                S_ADDIWB:  state <= S_FETCH;
                S_JUMP:    state <= S_FETCH;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of the control word; anything not set stays 0
    always_comb begin
        c        = '0;
        c.alu_op = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                c.alu_src_b = SRCB_FOUR;
                c.pc_src    = PCSRC_ALU;
                c.ir_write  = 1'b1;
                c.pc_write  = 1'b1;
            end
            S_DECODE: begin
                // Branch target precomputed while the opcode is decoded
                c.alu_src_b = SRCB_IMM_SH;
            end
            S_MEMADR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: c.iord = 1'b1;
            S_MEMWB: begin
                c.mem_to_reg = 1'b1;
                c.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTE: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_B;
                c.alu_op    = ALUOP_SUB;
                c.pc_src    = PCSRC_ALUOUT;
                c.branch    = 1'b1;
            end
            S_ADDIEX: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: c.reg_write = 1'b1;
            S_JUMP: begin
                c.pc_src   = PCSRC_JUMP;
                c.pc_write = 1'b1;
            end
            default: c.alu_src_b = SRCB_FOUR;
        endcase
    end

    // Write enables are held off combinationally while reset is asserted so
    // an aborted instruction cannot leave a partial write behind
    assign ctl.ALU_control = alu_control;
    assign ctl.ALUSrcA     = c.alu_src_a;
    assign ctl.ALUSrcB     = c.alu_src_b;
    assign ctl.PCSrc       = c.pc_src;
    assign ctl.IorD        = c.iord;
    assign ctl.RegDst      = c.reg_dst;
    assign ctl.MemtoReg    = c.mem_to_reg;
    assign ctl.IRWrite     = rst_n & c.ir_write;
    assign ctl.MemWrite    = rst_n & c.mem_write;
    assign ctl.RegWrite    = rst_n & c.reg_write;
    assign ctl.PCEn        = rst_n & (c.pc_write | (c.branch & ctl.zero_sig));
    assign ctl.Illegal_op  = illegal_op;
    assign ctl.State       = STATE_W'(state);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: directed instructions plus random streams.
// Latency: n/a.
// Backpressure: n/a.
module tb_mips_multicycle_control;
    import mips_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    bit   pend_ill;

    mips_multicycle_control_if bus ();

    mips_multicycle_control #(.STATE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    function automatic bit is_legal(input logic [5:0] op);
        return op == 6'b100011 || op == 6'b101011 || op == 6'b000000 ||
               op == 6'b000100 || op == 6'b001000 || op == 6'b000010;
    endfunction

    function automatic bit known_funct(input logic [5:0] f);
        return f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
               f == 6'b100101 || f == 6'b101010;
    endfunction

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Expected output vector for one cycle, straight from the per-state table:
    // {State, ALU_control, ALUSrcA, ALUSrcB, PCSrc, IorD, IRWrite, MemWrite,
    //  RegDst, MemtoReg, RegWrite, PCEn, Illegal_op}
    function automatic logic [19:0] expect_vec(input int st, input logic [5:0] f,
                                               input bit z, input bit ill);
        logic [2:0] aluc = 3'b010;
        logic       srca = 0, iord = 0, irw = 0, mw = 0, rdst = 0, m2r = 0, rw = 0, pcen = 0;
        logic [1:0] srcb = 2'b00, pcs = 2'b00;
        case (st)
            0:  begin srcb = 2'b01; irw = 1; pcen = 1; end
            1:  srcb = 2'b11;
            2:  begin srca = 1; srcb = 2'b10; end
            3:  iord = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin iord = 1; mw = 1; end
            6:  begin srca = 1; aluc = funct_alu(f); end
            7:  begin rdst = 1; rw = 1; end
            8:  begin srca = 1; aluc = 3'b110; pcs = 2'b01; pcen = z; end
            9:  begin srca = 1; srcb = 2'b10; end
            10: rw = 1;
            11: begin pcs = 2'b10; pcen = 1; end
            default: ;
        endcase
        return {4'(st), aluc, srca, srcb, pcs, iord, irw, mw, rdst, m2r, rw, pcen, ill};
    endfunction

    function automatic logic [19:0] actual_vec();
        return {bus.State, bus.ALU_control, bus.ALUSrcA, bus.ALUSrcB, bus.PCSrc,
                bus.IorD, bus.IRWrite, bus.MemWrite, bus.RegDst, bus.MemtoReg,
                bus.RegWrite, bus.PCEn, bus.Illegal_op};
    endfunction

    // Runs one instruction starting in FETCH; stops inside step abort_at if >= 0.
    // Op/Funct are scrambled in every cycle where the controller must ignore them.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] funct,
                             input string name, input int abort_at,
                             input int force_zero);
        int seq[$];
        case (op)
            6'b100011: seq = {0, 1, 2, 3, 4};
            6'b101011: seq = {0, 1, 2, 5};
            6'b000000: seq = {0, 1, 6, 7};
            6'b001000: seq = {0, 1, 9, 10};
            6'b000100: seq = {0, 1, 8};
            6'b000010: seq = {0, 1, 11};
            default:   seq = {0, 1};
        endcase
        for (int i = 0; i < seq.size(); i++) begin
            bit          z;
            bit          ill;
            logic [19:0] exp_v;
            logic [19:0] act_v;
            #2;
            bus.Op    = (seq[i] == 1) ? op : 6'($urandom);
            bus.Funct = (seq[i] == 6) ? funct : 6'($urandom);
            z = (force_zero >= 0 && seq[i] == 8) ? 1'(force_zero) : 1'($urandom);
            bus.zero_sig = z;
            #1;
            ill   = (i == 0 && pend_ill) || (seq[i] == 7 && !known_funct(funct));
            exp_v = expect_vec(seq[i], funct, z, ill);
            act_v = actual_vec();
            checks++;
            if (act_v !== exp_v)
                begin
                    errors++;
                    $display("FAIL %s step %0d: got %h required %h", name, i, act_v, exp_v);
                end
            if (i == abort_at) return;
            @(posedge clk);
        end
        pend_ill = !is_legal(op);
    endtask

    task automatic test_reset();
        logic [19:0] exp_v;
        rst_n        = 1'b0;
        bus.Op       = 6'($urandom);
        bus.Funct    = 6'($urandom);
        bus.zero_sig = 1'b1;
        // FETCH decode with every write enable suppressed
        exp_v = {4'd0, 3'b010, 1'b0, 2'b01, 2'b00, 8'b0};
        for (int k = 0; k < 2; k++) begin
            #3;
            checks++;
            if (actual_vec() !== exp_v) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got %h required %h", k, actual_vec(), exp_v);
            end
            @(posedge clk);
        end
        #1 rst_n = 1'b1;
        pend_ill = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'($urandom), "lw", -1, -1);
    endtask

    task automatic test_rtype();
        run_instr(6'b000000, 6'b101010, "slt", -1, -1);
        run_instr(6'b000000, 6'b100100, "and", -1, -1);
        run_instr(6'b000000, 6'b111000, "badfunct", -1, -1);
        run_instr(6'b001000, 6'($urandom), "addi", -1, -1);
    endtask

    task automatic test_beq();
        run_instr(6'b000100, 6'($urandom), "beq_taken", -1, 1);
        run_instr(6'b000100, 6'($urandom), "beq_not_taken", -1, 0);
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'($urandom), "illegal", -1, -1);
        run_instr(6'b000010, 6'($urandom), "j_after_illegal", -1, -1);
    endtask

    task automatic test_reset_mid();
        run_instr(6'b101011, 6'($urandom), "sw_abort", 3, -1);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.State !== 4'd0) begin
            errors++;
            $display("FAIL abort_state: got %0d required 0", bus.State);
        end
        checks++;
        if (bus.MemWrite !== 1'b0) begin
            errors++;
            $display("FAIL abort_memwrite: got %b required 0", bus.MemWrite);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus.State, bus.RegWrite, bus.IRWrite, bus.PCEn} !== 7'b0) begin
            errors++;
            $display("FAIL abort_hold: got %b required 0000000",
                     {bus.State, bus.RegWrite, bus.IRWrite, bus.PCEn});
        end
        rst_n    = 1'b1;
        pend_ill = 1'b0;
        run_instr(6'b100011, 6'($urandom), "lw_after_abort", -1, -1);
    endtask

    task automatic test_random();
        logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int sel = int'($urandom_range(0, 6));
            if (sel == 6) begin
                op = 6'($urandom);
                while (is_legal(op)) op = 6'($urandom);
            end else begin
                op = ops[sel];
            end
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            run_instr(op, fn, "random", -1, -1);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        pend_ill = 1'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_beq();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
